hdlc_tx_ctrl: RTL

//  Transmit sequencer for the HDLC serial link. Takes bytes from the TX buffer over a valid/ack handshake and emits one line bit per clk_i.

---
 rtl/hdlc_tx_ctrl_if.sv | 9 +
 rtl/hdlc_tx_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_tx_ctrl_if.sv
// Byte handshake between the TX buffer (master) and the HDLC transmit sequencer (slave).
interface hdlc_tx_ctrl_if;
  logic [7:0] data_i;
  logic       data_valid;
  logic       data_ack;

  modport master (output data_i, output data_valid, input data_ack);
  modport slave  (input data_i, input data_valid, output data_ack);
endinterface

// File: rtl/hdlc_tx_ctrl.sv
// HDLC transmit sequencer: opening flags, zero-stuffed payload, closing flag and abort pattern.
// Define HDLC_TX_FCS_EN to append the CRC-16/X.25 frame check sequence before the closing flag.
module hdlc_tx_ctrl #(
  parameter int OPEN_FLAGS = 1,
  parameter int ABORT_ONES = 7
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          txen,
  input  logic          frame,
  input  logic          abortframe,
  hdlc_tx_ctrl_if.slave buf_if,
  output logic          tx,
  output logic          txdone,
  output logic          busy
);
  localparam int FW = (OPEN_FLAGS > 1) ? $clog2(OPEN_FLAGS) : 1;
  localparam int AW = $clog2(ABORT_ONES);
  localparam logic [FW-1:0] LAST_FLAG = FW'(OPEN_FLAGS - 1);
  localparam logic [AW-1:0] LAST_ONE  = AW'(ABORT_ONES - 1);
  localparam logic [7:0]    FLAG      = 8'h7E;

  typedef enum logic [2:0] {
    IDLE, PREP, FLAG_OPEN, DATA, FLAG_CLOSE, ABORT, ABORT_FLAG
`ifdef HDLC_TX_FCS_EN
    , FCS
`endif
  } state_t;

  state_t          state_q;
  state_t          bnd_state;
  logic            frame_q, abort_q;
  logic            tx_q, ack_q, done_q, done_pend_q;
  logic [2:0]      bit_cnt_q, ones_q;
  logic [FW-1:0]   flag_cnt_q;
  logic [AW-1:0]   abort_cnt_q;
  logic [7:0]      shift_q;
  logic            rise_f, rise_a, abort_ok, stuff, cur_bit, at_bnd;

  assign rise_f   = frame & ~frame_q;
  assign rise_a   = abortframe & ~abort_q;
  assign abort_ok = rise_a && (state_q != ABORT) && (state_q != ABORT_FLAG);
  assign stuff    = (ones_q == 3'd5);
  assign cur_bit  = shift_q[bit_cnt_q];
  assign at_bnd   = (bit_cnt_q == 3'd7) &&
                    (((state_q == FLAG_OPEN) && (flag_cnt_q == LAST_FLAG)) ||
                     ((state_q == DATA) && !stuff));

`ifdef HDLC_TX_FCS_EN
  logic [15:0] crc_q, crc_d;
  logic [3:0]  fcs_cnt_q;
  logic        fcs_bit;
  assign crc_d   = (crc_q[0] ^ cur_bit) ? ((crc_q >> 1) ^ 16'h8408) : (crc_q >> 1);
  assign fcs_bit = ~crc_q[fcs_cnt_q];
`endif

  // Where a byte boundary leads: next byte, end of payload, or underrun abort.
  always_comb begin
    bnd_state = ABORT;
    if (!frame) begin
`ifdef HDLC_TX_FCS_EN
      bnd_state = FCS;
`else
      bnd_state = FLAG_CLOSE;
`endif
    end else if (buf_if.data_valid) begin
      bnd_state = DATA;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      frame_q     <= 1'b0;
      abort_q     <= 1'b0;
      tx_q        <= 1'b1;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      done_pend_q <= 1'b0;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      flag_cnt_q  <= '0;
      abort_cnt_q <= '0;
      shift_q     <= '0;
`ifdef HDLC_TX_FCS_EN
      crc_q       <= 16'hFFFF;
      fcs_cnt_q   <= '0;
`endif
    end else begin
      frame_q     <= frame;
      abort_q     <= abortframe;
      ack_q       <= 1'b0;
      done_q      <= done_pend_q;
      done_pend_q <= 1'b0;
      if (!txen) begin
        state_q <= IDLE;
        tx_q    <= 1'b1;
        done_q  <= 1'b0;
        ones_q  <= '0;
`ifdef HDLC_TX_FCS_EN
        crc_q   <= 16'hFFFF;
`endif
      end else if (abort_ok) begin
        state_q     <= ABORT;
        tx_q        <= 1'b1;
        abort_cnt_q <= '0;
        ones_q      <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            tx_q <= 1'b1;
            if (rise_f) state_q <= PREP;
          end
          PREP: begin
            tx_q       <= 1'b1;
            bit_cnt_q  <= '0;
            flag_cnt_q <= '0;
            ones_q     <= '0;
`ifdef HDLC_TX_FCS_EN
            crc_q      <= 16'hFFFF;
`endif
            state_q    <= FLAG_OPEN;
          end
          FLAG_OPEN: begin
            tx_q      <= FLAG[bit_cnt_q];
            ones_q    <= '0;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) flag_cnt_q <= flag_cnt_q + FW'(1);
          end
          DATA: begin
            if (stuff) begin
              tx_q   <= 1'b0;
              ones_q <= '0;
            end else begin
              tx_q      <= cur_bit;
              ones_q    <= cur_bit ? ones_q + 3'd1 : 3'd0;
              bit_cnt_q <= bit_cnt_q + 3'd1;
`ifdef HDLC_TX_FCS_EN
              crc_q     <= crc_d;
`endif
            end
          end
`ifdef HDLC_TX_FCS_EN
          FCS: begin
            if (stuff) begin
              tx_q   <= 1'b0;
              ones_q <= '0;
            end else begin
              tx_q      <= fcs_bit;
              ones_q    <= fcs_bit ? ones_q + 3'd1 : 3'd0;
              fcs_cnt_q <= fcs_cnt_q + 4'd1;
              if (fcs_cnt_q == 4'd15) begin
                state_q   <= FLAG_CLOSE;
                bit_cnt_q <= '0;
              end
            end
          end
`endif
          // A pending stuffed 0 must precede the closing flag, otherwise the flag reads as data.
          FLAG_CLOSE: begin
            if (stuff) begin
              tx_q   <= 1'b0;
              ones_q <= '0;
            end else begin
              tx_q      <= FLAG[bit_cnt_q];
              ones_q    <= '0;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q     <= IDLE;
                done_pend_q <= 1'b1;
              end
            end
          end
          ABORT: begin
            tx_q   <= 1'b1;
            ones_q <= '0;
`ifdef HDLC_TX_FCS_EN
            crc_q  <= 16'hFFFF;
`endif
            if (abort_cnt_q == LAST_ONE) begin
              state_q   <= ABORT_FLAG;
              bit_cnt_q <= '0;
            end else begin
              abort_cnt_q <= abort_cnt_q + AW'(1);
            end
          end
          ABORT_FLAG: begin
            tx_q      <= FLAG[bit_cnt_q];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
          end
        endcase
        if (at_bnd) begin
          state_q     <= bnd_state;
          abort_cnt_q <= '0;
`ifdef HDLC_TX_FCS_EN
          fcs_cnt_q   <= '0;
`endif
          if (bnd_state == DATA) begin
            shift_q <= buf_if.data_i;
            ack_q   <= 1'b1;
          end
        end
      end
    end
  end

  assign tx              = tx_q;
  assign txdone          = done_q;
  assign busy            = (state_q != IDLE);
  assign buf_if.data_ack = ack_q;
endmodule
